// File: rtl/bk_mon_pkg.sv
// bk_mon_pkg: shared types, counter widths and default qualification windows
// for the breakdown feedback pulse monitor.
package bk_mon_pkg;

   typedef enum logic [1:0] {S_WAIT, S_HIGH, S_LOW} bk_state_e;

   localparam int W_CW = 12;
   localparam int P_CW = 20;

   localparam int DEF_NCH       = 6;
   localparam int DEF_W_MIN     = 500;
   localparam int DEF_W_MAX     = 1250;
   localparam int DEF_P_MIN     = 400000;
   localparam int DEF_P_MAX     = 600000;
   localparam int DEF_T_OUT     = 1000000;
   localparam int DEF_CONFIRM_N = 3;

   function automatic logic in_win(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/bk_pulse_chan.sv
// bk_pulse_chan: one feedback channel - synchroniser, width/period counters,
// pulse qualification FSM and ok/lost/err/evt flags.
module bk_pulse_chan
   import bk_mon_pkg::*;
#(
   parameter int W_MIN     = DEF_W_MIN,
   parameter int W_MAX     = DEF_W_MAX,
   parameter int P_MIN     = DEF_P_MIN,
   parameter int P_MAX     = DEF_P_MAX,
   parameter int T_OUT     = DEF_T_OUT,
   parameter int CONFIRM_N = DEF_CONFIRM_N
) (
   input  logic i_clk_25m,
   input  logic i_rst_n,
   input  logic i_bk_pulse,
   input  logic i_err_clr,
   output logic o_bk_ok,
   output logic o_bk_lost,
   output logic o_bk_err,
   output logic o_bk_evt
);

   localparam int G_W = $clog2(CONFIRM_N + 1);

   logic            sync1_q, sync1_d, sig_s_q, sig_s_d, sig_d_q, sig_d_d;
   logic            rise_q, rise_d, fall_q, fall_d;
   logic [P_CW-1:0] p_cnt_q, p_cnt_d, per_meas_q, per_meas_d;
   logic [W_CW-1:0] w_cnt_q, w_cnt_d;
   logic [G_W-1:0]  good_q, good_d;
   logic            first_q, first_d, ok_q, ok_d, lost_q, lost_d;
   logic            err_q, err_d, evt_q, evt_d;
   bk_state_e       state_q, state_d;
   logic            tout, qual;

   always_comb begin
      sync1_d    = i_bk_pulse;
      sig_s_d    = sync1_q;
      sig_d_d    = sig_s_q;
      // edges are registered so the FSM sees them one clk after detection
      rise_d     = sig_s_q & ~sig_d_q;
      fall_d     = ~sig_s_q & sig_d_q;
      tout       = (p_cnt_q == P_CW'(T_OUT)) & ~rise_q;
      qual       = in_win(int'(w_cnt_q), W_MIN, W_MAX) &&
                   (first_q || in_win(int'(per_meas_q), P_MIN, P_MAX));
      p_cnt_d    = rise_q ? P_CW'(1) : p_cnt_q + P_CW'(~&p_cnt_q);
      per_meas_d = rise_q ? p_cnt_q : per_meas_q;
      w_cnt_d    = (state_q == S_HIGH) ? w_cnt_q + W_CW'(~&w_cnt_q) : w_cnt_q;
      state_d    = state_q;
      first_d    = first_q;
      good_d     = good_q;
      lost_d     = lost_q;
      err_d      = err_q & ~i_err_clr;
      evt_d      = 1'b0;
      if (tout) begin
         state_d = S_WAIT;
         lost_d  = 1'b1;
         err_d   = 1'b1;
         good_d  = '0;
      end else if (rise_q && state_q != S_HIGH) begin
         state_d = S_HIGH;
         w_cnt_d = W_CW'(1);
         first_d = (state_q == S_WAIT);
      end else if (fall_q && state_q == S_HIGH) begin
         state_d = S_LOW;
         evt_d   = qual;
         good_d  = qual ? good_q + G_W'(good_q != G_W'(CONFIRM_N)) : '0;
         lost_d  = lost_q & ~qual;
         err_d   = err_d | ~qual;
      end
      ok_d = (good_d == G_W'(CONFIRM_N));
   end

   always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q    <= 1'b0;
         sig_s_q    <= 1'b0;
         sig_d_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         p_cnt_q    <= '0;
         per_meas_q <= '0;
         w_cnt_q    <= '0;
         good_q     <= '0;
         first_q    <= 1'b0;
         ok_q       <= 1'b0;
         lost_q     <= 1'b0;
         err_q      <= 1'b0;
         evt_q      <= 1'b0;
         state_q    <= S_WAIT;
      end else begin
         sync1_q    <= sync1_d;
         sig_s_q    <= sig_s_d;
         sig_d_q    <= sig_d_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         p_cnt_q    <= p_cnt_d;
         per_meas_q <= per_meas_d;
         w_cnt_q    <= w_cnt_d;
         good_q     <= good_d;
         first_q    <= first_d;
         ok_q       <= ok_d;
         lost_q     <= lost_d;
         err_q      <= err_d;
         evt_q      <= evt_d;
         state_q    <= state_d;
      end
   end

   assign o_bk_ok   = ok_q;
   assign o_bk_lost = lost_q;
   assign o_bk_err  = err_q;
   assign o_bk_evt  = evt_q;

endmodule

// File: rtl/bk_pulse_monitor.sv
// bk_pulse_monitor: NCH independent breakdown feedback channel monitors
// sharing one clock, reset and error-clear strobe.
module bk_pulse_monitor
   import bk_mon_pkg::*;
#(
   parameter int NCH       = DEF_NCH,
   parameter int W_MIN     = DEF_W_MIN,
   parameter int W_MAX     = DEF_W_MAX,
   parameter int P_MIN     = DEF_P_MIN,
   parameter int P_MAX     = DEF_P_MAX,
   parameter int T_OUT     = DEF_T_OUT,
   parameter int CONFIRM_N = DEF_CONFIRM_N
) (
   input  logic           i_clk_25m,
   input  logic           i_rst_n,
   input  logic [NCH-1:0] i_bk_pulse,
   input  logic           i_err_clr,
   output logic [NCH-1:0] o_bk_ok,
   output logic [NCH-1:0] o_bk_lost,
   output logic [NCH-1:0] o_bk_err,
   output logic [NCH-1:0] o_bk_evt
);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      bk_pulse_chan #(
         .W_MIN     (W_MIN),
         .W_MAX     (W_MAX),
         .P_MIN     (P_MIN),
         .P_MAX     (P_MAX),
         .T_OUT     (T_OUT),
         .CONFIRM_N (CONFIRM_N)
      ) u_chan (
         .i_clk_25m  (i_clk_25m),
         .i_rst_n    (i_rst_n),
         .i_bk_pulse (i_bk_pulse[c]),
         .i_err_clr  (i_err_clr),
         .o_bk_ok    (o_bk_ok[c]),
         .o_bk_lost  (o_bk_lost[c]),
         .o_bk_err   (o_bk_err[c]),
         .o_bk_evt   (o_bk_evt[c])
      );
   end

endmodule

// File: tb/tb_bk_pulse_monitor.sv
// tb_bk_pulse_monitor: random pulse trains on all channels, checked against a
// timestamp-based reference model of the qualification rules (scaled windows).
module tb_bk_pulse_monitor;

   localparam int NCH = 6;
   localparam int WMN = 50;
   localparam int WMX = 125;
   localparam int PMN = 1000;
   localparam int PMX = 1500;
   localparam int TO  = 2500;
   localparam int CN  = 3;

   typedef struct packed {
      logic [NCH-1:0] evt;
      logic [NCH-1:0] ok;
      logic [NCH-1:0] lost;
      logic [NCH-1:0] err;
   } obs_t;

   logic           clk     = 1'b0;
   logic           rst_n   = 1'b0;
   logic           err_clr = 1'b0;
   logic [NCH-1:0] pulse   = '0;
   logic [NCH-1:0] ok, lost, err, evt;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int mode = 2;
   int rem [NCH];
   int lo [NCH];
   logic [NCH-1:0] lvl = '0;

   int last_rise [NCH];
   int hi_start [NCH];
   int good [NCH];
   logic [NCH-1:0] armed, in_hi, per_ok, lost_m, prev_raw, err_m;
   logic clr_prev;
   obs_t hist [8];
   obs_t exp_prev;

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bk_pulse_monitor #(
      .NCH(NCH), .W_MIN(WMN), .W_MAX(WMX), .P_MIN(PMN), .P_MAX(PMX),
      .T_OUT(TO), .CONFIRM_N(CN)
   ) dut (
      .i_clk_25m  (clk),
      .i_rst_n    (rst_n),
      .i_bk_pulse (pulse),
      .i_err_clr  (err_clr),
      .o_bk_ok    (ok),
      .o_bk_lost  (lost),
      .o_bk_err   (err),
      .o_bk_evt   (evt)
   );

   task automatic chk(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %b want %b", tag, cyc, got, want);
         if (n_fail >= 30) begin
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   endtask

   task automatic draw(input int md, output int h, output int p);
      int k = $urandom_range(0, 99);
      int k2 = $urandom_range(0, 99);
      h = $urandom_range(WMN, WMX);
      p = $urandom_range(PMN, PMX);
      if (md == 0) begin
         if (k < 8) begin
            case ($urandom_range(0, 3))
               0: h = WMN - 1;
               1: h = WMN;
               2: h = WMX;
               default: h = WMX + 1;
            endcase
         end else if (k < 12) h = $urandom_range(5, WMN - 1);
         else if (k < 15) h = $urandom_range(WMX + 1, 400);
         if (k2 < 10) begin
            case ($urandom_range(0, 3))
               0: p = PMN - 1;
               1: p = PMN;
               2: p = PMX;
               default: p = PMX + 1;
            endcase
         end else if (k2 < 14) p = $urandom_range(500, PMN - 1);
         else if (k2 < 18) begin
            case ($urandom_range(0, 2))
               0: p = TO;
               1: p = TO + 1;
               default: p = TO + $urandom_range(2, 300);
            endcase
         end
         if (k >= 97) h = TO + $urandom_range(1, 200);
      end
      if (p < h + 4) p = h + 4;
   endtask

   task automatic step_gen();
      int h, p;
      for (int c = 0; c < NCH; c++) begin
         if (mode == 2) begin
            lvl[c] = 1'b0;
            rem[c] = $urandom_range(1, 200);
         end else begin
            if (rem[c] == 0) begin
               if (lvl[c]) begin
                  lvl[c] = 1'b0;
                  rem[c] = lo[c];
               end else begin
                  draw(mode, h, p);
                  lvl[c] = 1'b1;
                  rem[c] = h;
                  lo[c]  = p - h;
               end
            end
            rem[c]--;
         end
      end
      pulse = lvl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      step_gen();
      err_clr = (mode == 0) && ($urandom_range(0, 199) == 0);
   endtask

   // Raw edges at cycle n become visible on the outputs at cycle n+4;
   // error-clear acts one cycle after it is driven.
   task automatic model_step();
      obs_t h, d, e;
      int w, per;
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            last_rise[c] = cyc - 2;
            good[c] = 0;
         end
         armed = '0; in_hi = '0; per_ok = '0; lost_m = '0; prev_raw = '0; err_m = '0;
         clr_prev = 1'b0;
         exp_prev = '0;
         for (int i = 0; i < 8; i++) hist[i] = '0;
         return;
      end
      h = '0;
      for (int c = 0; c < NCH; c++) begin
         per = cyc - last_rise[c];
         if (pulse[c] && !prev_raw[c]) begin
            per_ok[c] = !armed[c] || (per >= PMN && per <= PMX);
            armed[c] = 1'b1;
            in_hi[c] = 1'b1;
            last_rise[c] = cyc;
            hi_start[c] = cyc;
         end else if (per == TO) begin
            armed[c] = 1'b0;
            in_hi[c] = 1'b0;
            lost_m[c] = 1'b1;
            good[c] = 0;
            h.err[c] = 1'b1;
         end
         if (!pulse[c] && prev_raw[c] && in_hi[c]) begin
            w = cyc - hi_start[c];
            in_hi[c] = 1'b0;
            if (w >= WMN && w <= WMX && per_ok[c]) begin
               h.evt[c] = 1'b1;
               lost_m[c] = 1'b0;
               if (good[c] < CN) good[c]++;
            end else begin
               good[c] = 0;
               h.err[c] = 1'b1;
            end
         end
         h.ok[c] = (good[c] == CN);
         h.lost[c] = lost_m[c];
      end
      prev_raw = pulse;
      hist[cyc % 8] = h;
      d = hist[(cyc + 4) % 8];
      err_m = d.err | (clr_prev ? '0 : err_m);
      e = {d.evt, d.ok, d.lost, err_m};
      if (evt !== e.evt || e.evt != '0 || cyc % 500 == 0) chk("evt", evt, e.evt);
      if (ok !== e.ok || e.ok != exp_prev.ok || cyc % 500 == 0) chk("ok", ok, e.ok);
      if (lost !== e.lost || e.lost != exp_prev.lost || cyc % 500 == 0) chk("lost", lost, e.lost);
      if (err !== e.err || e.err != exp_prev.err || cyc % 500 == 0) chk("err", err, e.err);
      exp_prev = e;
      clr_prev = err_clr;
   endtask

   initial forever begin
      @(negedge clk);
      model_step();
   end

   initial begin
      mode = 2;
      repeat (5) tick();
      chk("rst_ok", ok, '0);
      chk("rst_lost", lost, '0);
      chk("rst_err", err, '0);
      chk("rst_evt", evt, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mode = 0;
      repeat (50000) tick();
      mode = 1;
      repeat (9000) tick();
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (&ok && pulse[0]) break;
      end
      chk("pre_rst_ok", ok, '1);
      #2;
      rst_n = 1'b0;
      mode = 2;
      #1;
      chk("arst_ok", ok, '0);
      chk("arst_lost", lost, '0);
      chk("arst_err", err, '0);
      chk("arst_evt", evt, '0);
      repeat (4) tick();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mode = 1;
      repeat (6000) tick();
      chk("post_rst_ok", ok, '1);
      chk("post_rst_err", err, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bk_pulse_monitor.md
Name: bk_pulse_monitor

Overview:
- Downstream consumer of the 6-channel breakdown feedback pulse train: 876-clk high pulse every 500001 clks (~20 ms) at 25 MHz.
- Per channel: synchronises the input, measures pulse width and rise-to-rise period, and qualifies each pulse against windows.
- Reports per-channel healthy (after CONFIRM_N consecutive qualified pulses), lost (timeout) and sticky error flags to the box controller.

Parameters:
- NCH, 6, number of feedback channels.
- W_MIN, 500, minimum accepted high width (clks).
- W_MAX, 1250, maximum accepted high width (clks).
- P_MIN, 400000, minimum accepted rise-to-rise period (clks).
- P_MAX, 600000, maximum accepted rise-to-rise period (clks).
- T_OUT, 1000000, clks since last rise before channel declared lost (40 ms).
- CONFIRM_N, 3, consecutive qualified pulses needed for o_bk_ok.

Ports:
- i_clk_25m  in  1  25 MHz clock, single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bk_pulse  in  NCH  raw feedback pulses, asynchronous to clock.
- i_err_clr  in  1  synchronous one-cycle clear of all o_bk_err bits.
- o_bk_ok  out  NCH  channel healthy (level).
- o_bk_lost  out  NCH  no rising edge for T_OUT clks (level).
- o_bk_err  out  NCH  sticky: an unqualified pulse was seen.
- o_bk_evt  out  NCH  one-cycle strobe per qualified pulse.

Behaviour:
- Reset (async, active-low) clears all outputs, sync FFs, counters and good_cnt to 0; every FSM goes to S_WAIT.
- Input sync: 2-FF synchroniser per channel, then a delay FF (sig_d).
  - rise = sig_s & ~sig_d; fall = ~sig_s & sig_d.
- Counters per channel, both saturating, never wrap:
  - w_cnt: 12 bit, saturates at 4095.
  - p_cnt: 20 bit, saturates at 2^20-1.
- p_cnt increments every clk; it loads 1 on rise.
  - On rise, the pre-load p_cnt value is latched as per_meas.
- FSM per channel, states S_WAIT, S_HIGH, S_LOW:
  - S_WAIT (no valid period reference): on rise -> S_HIGH, w_cnt=1, first_f=1.
  - S_HIGH: w_cnt++ each clk. On fall, evaluate the pulse, then -> S_LOW.
  - S_LOW: on rise -> S_HIGH, w_cnt=1, first_f=0.
- Qualified pulse: evaluated in the fall cycle.
  - Width: W_MIN <= w_cnt <= W_MAX.
  - Period: first_f=1, or P_MIN <= per_meas <= P_MAX.
- Qualified pulse result, registered:
  - o_bk_evt pulses high for 1 clk.
  - good_cnt++ (saturates at CONFIRM_N).
  - o_bk_lost cleared.
- Unqualified pulse result: good_cnt=0, o_bk_ok=0, o_bk_err=1.
- o_bk_ok = (good_cnt == CONFIRM_N), registered.
- Latency: raw falling edge to o_bk_evt/o_bk_ok update is 4 clks (2 sync + edge detect + output register).
- Timeout: p_cnt reaching T_OUT in any state (including stuck-high in S_HIGH) forces:
  - o_bk_lost=1, o_bk_ok=0, o_bk_err=1, good_cnt=0, FSM -> S_WAIT.
  - Lost stays set until the next qualified pulse.
- A pulse with w_cnt > W_MAX that falls before T_OUT is unqualified. It does not set lost.
- Simultaneous events:
  - rise and timeout in the same clk: rise wins; no lost; per_meas = T_OUT is out of window, so the following pulse is unqualified.
  - i_err_clr and a new error in the same clk: error wins, o_bk_err stays 1.
- Channels are fully independent; a fault on one never affects another.

Decomposition:
- Package bk_mon_pkg:
  - FSM state enum (S_WAIT/S_HIGH/S_LOW).
  - Counter widths W_CW=12, P_CW=20.
  - Default window constants.
- Sub-module bk_pulse_chan holds the sync, counters, FSM and flags for one channel.
- Top generates NCH instances and shares i_err_clr.

Test Plan:
- Nominal: all channels 876 clk high every 500001 clks -> o_bk_evt at each fall+4 clks; o_bk_ok=1 after the 3rd pulse; o_bk_err=0, o_bk_lost=0.
- Width fault: ch2 one pulse of 300 clks after ok -> ch2 o_bk_ok=0, o_bk_err=1, no evt that pulse; ch2 ok again after 3 further good pulses; other channels unaffected.
- Period fault: ch0 pulses at 300000-clk spacing -> every non-first pulse unqualified, o_bk_ok never 1, o_bk_err=1; i_err_clr then 500001 spacing -> err cleared, ok after 3 pulses.
- Loss / stuck-high:
  - ch5 held low after ok -> o_bk_lost=1 exactly when p_cnt=1000000 (1000000 clks after last sync'd rise); ok=0.
  - ch4 held high -> same lost behaviour, FSM S_WAIT.
  - Recovery: next good pulse clears lost.
- Reset mid-operation: assert i_rst_n=0 during a high pulse with ok=1 -> all outputs 0 immediately (async); after release, the first pulse counts as first_f; ok after 3 pulses.
- Boundary windows: widths 500 and 1250, periods 400000 and 600000 -> qualified; widths 499/1251 and periods 399999/600001 -> unqualified.
